// File: rtl/vga_seq_pkg.sv
// Shared definitions for the VGA demo sequencer: state encodings, LFSR taps, default seed.
// Latency: n/a. Backpressure: n/a.
package vga_seq_pkg;

  typedef enum logic [1:0] {
    S_TP24   = 2'd0,
    S_TP3    = 2'd1,
    S_DEMO24 = 2'd2,
    S_DEMO3  = 2'd3
  } seq_state_t;

  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE10001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return {r[30:0], r[LFSR_TAP_A] ^ r[LFSR_TAP_B] ^ r[LFSR_TAP_C] ^ r[LFSR_TAP_D]};
  endfunction

  // Strict ring order; there is no other legal transition.
  function automatic seq_state_t seq_next(input seq_state_t s);
    case (s)
      S_TP24:   return S_TP3;
      S_TP3:    return S_DEMO24;
      S_DEMO24: return S_DEMO3;
      default:  return S_TP24;
    endcase
  endfunction

endpackage

// File: rtl/vga_demo_seq_btn_debounce.sv
// Two-flop synchroniser plus stability debounce for one raw button or switch.
// Latency: 2 sync cycles + DEBOUNCE_CYC stable cycles before the level follows.
// Backpressure: none; free-running level output.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 400000
) (
  input  logic clk_dot,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk_dot or posedge reset) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable_cnt <= '0;
      btn_db     <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      // Any return to the debounced level restarts the stability window.
      if (sync_q2 == btn_db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        btn_db     <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_demo_seq.sv
// Frame-synchronous sequencer stepping the pattern core through TP24/TP3/DEMO24/DEMO3.
// Latency: frame_tick 1 cycle after vsync activation; state changes at the edge ending frame_tick.
// Backpressure: none; button presses collapse into a single pending step per frame.
module vga_demo_seq
  import vga_seq_pkg::*;
#(
  parameter int          FRAMES_PER_STATE = 600,
  parameter int          DEBOUNCE_CYC     = 400000,
  parameter bit          VSYNC_ACT_LOW    = 1'b0,
  parameter logic [31:0] LFSR_SEED        = LFSR_SEED_DEFAULT
) (
  input  logic        clk_dot,
  input  logic        reset,
  input  logic        vga_vsync,
  input  logic        btn_next,
  input  logic        btn_hold,
  output logic        mode_bit,
  output logic        color_3b,
  output logic [31:0] random_num,
  output logic [1:0]  seq_state,
  output logic        frame_tick
);

  localparam logic [15:0] CNT_LAST = 16'(FRAMES_PER_STATE - 1);

  logic        vs_act;
  logic        vs_prev;
  logic        next_db;
  logic        next_db_q;
  logic        hold_db;
  logic        next_rise;
  logic        advance;
  logic        pending;
  logic        pending_d;
  logic [15:0] frame_cnt;
  logic [15:0] frame_cnt_d;
  logic [31:0] lfsr;
  logic [1:0]  state_bits;
  seq_state_t  state;
  seq_state_t  state_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk_dot (clk_dot),
    .reset   (reset),
    .btn_raw (btn_next),
    .btn_db  (next_db)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_hold (
    .clk_dot (clk_dot),
    .reset   (reset),
    .btn_raw (btn_hold),
    .btn_db  (hold_db)
  );

  assign vs_act    = vga_vsync ^ VSYNC_ACT_LOW;
  assign next_rise = next_db & ~next_db_q;

  // vs_prev resets to the active level so vsync already active at release is not a new frame.
  always_ff @(posedge clk_dot or posedge reset) begin
    if (reset) begin
      vs_prev    <= 1'b1;
      frame_tick <= 1'b0;
      next_db_q  <= 1'b0;
      state      <= S_TP24;
      frame_cnt  <= '0;
      pending    <= 1'b0;
    end else begin
      vs_prev    <= vs_act;
      frame_tick <= vs_act & ~vs_prev;
      next_db_q  <= next_db;
      state      <= state_d;
      frame_cnt  <= frame_cnt_d;
      pending    <= pending_d;
    end
  end

  always_comb begin
    state_d     = state;
    frame_cnt_d = frame_cnt;
    pending_d   = pending;
    advance     = frame_tick & (pending | (~hold_db & (frame_cnt == CNT_LAST)));
    if (advance) begin
      state_d     = seq_next(state);
      frame_cnt_d = '0;
      pending_d   = 1'b0;
    end else if (frame_tick && !hold_db && frame_cnt != CNT_LAST) begin
      frame_cnt_d = frame_cnt + 16'd1;
    end
    // A press landing on the advance cycle survives the clear.
    if (next_rise) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_dot or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == '0) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign state_bits = state;
  assign seq_state  = state_bits;
  assign mode_bit   = state_bits[1];
  assign color_3b   = state_bits[0];
  assign random_num = lfsr;

endmodule

// File: tb/tb_vga_demo_seq.sv
// Randomised frame/button stimulus against a frame-level reference model; a monitor scoreboards each frame_tick.
module tb_vga_demo_seq;

  localparam int FPS    = 3;
  localparam int DB     = 4;
  localparam bit VS_LOW = 1'b1;
  localparam int FRAME  = 100;

  logic        clk_dot = 1'b0;
  logic        reset;
  logic        vga_vsync;
  logic        btn_next;
  logic        btn_hold;
  logic        mode_bit;
  logic        color_3b;
  logic [31:0] random_num;
  logic [1:0]  seq_state;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  // Reference model: frames spent in state, pending press, hold level seen at the next frame.
  int         st_m   = 0;
  int         cnt_m  = 0;
  bit         pend_m = 1'b0;
  bit         hold_m = 1'b0;
  logic [1:0] exp_q[$];

  vga_demo_seq #(
    .FRAMES_PER_STATE (FPS),
    .DEBOUNCE_CYC     (DB),
    .VSYNC_ACT_LOW    (VS_LOW),
    .LFSR_SEED        (32'h0000_0001)
  ) dut (
    .clk_dot    (clk_dot),
    .reset      (reset),
    .vga_vsync  (vga_vsync),
    .btn_next   (btn_next),
    .btn_hold   (btn_hold),
    .mode_bit   (mode_bit),
    .color_3b   (color_3b),
    .random_num (random_num),
    .seq_state  (seq_state),
    .frame_tick (frame_tick)
  );

  always #5 clk_dot = ~clk_dot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    st_m   = 0;
    cnt_m  = 0;
    pend_m = 1'b0;
  endtask

  task automatic model_tick();
    bit auto_due;
    auto_due = !hold_m && (cnt_m == FPS - 1);
    if (pend_m || auto_due) begin
      st_m   = (st_m + 1) % 4;
      cnt_m  = 0;
      pend_m = 1'b0;
    end else if (!hold_m) begin
      cnt_m++;
    end
    exp_q.push_back(2'(st_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seq_state"}, 32'(seq_state), 32'd0);
    chk({tag, "_mode_bit"}, 32'(mode_bit), 32'd0);
    chk({tag, "_color_3b"}, 32'(color_3b), 32'd0);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    chk({tag, "_random_num"}, random_num, 32'd1);
  endtask

  // kind: 0 none, 1 one long press, 2 short glitch, 3 two long presses in the frame.
  task automatic run_frame(input int kind, input bit hold, input bit tick_exp, input bit do_reset);
    if (tick_exp) model_tick();
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk_dot);
      vga_vsync = (c < 10) ^ VS_LOW;
      if (c == 20) begin
        btn_hold = hold;
        hold_m   = hold;
      end
      btn_next = 1'b0;
      if ((kind == 1 || kind == 3) && c >= 30 && c < 40) btn_next = 1'b1;
      if (kind == 2 && c >= 30 && c < 32) btn_next = 1'b1;
      if (kind == 3 && c >= 60 && c < 70) btn_next = 1'b1;
      if ((kind == 1 || kind == 3) && c == 30) pend_m = 1'b1;
      if (kind == 3 && c == 60) pend_m = 1'b1;
      if (do_reset && c == 50) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrun_reset");
        model_reset();
        @(negedge clk_dot);
        @(negedge clk_dot);
        reset = 1'b0;
      end
    end
  endtask

  // Scoreboard monitor: pops one expected state per frame_tick and checks it after the tick cycle.
  logic [1:0] last_state = 2'd0;
  logic [1:0] prev_seq   = 2'd0;
  bit         prev_tick  = 1'b0;

  always @(negedge clk_dot) begin
    logic [1:0] e;
    if (reset) begin
      prev_tick  = 1'b0;
      last_state = 2'd0;
      prev_seq   = 2'd0;
    end else begin
      if (prev_tick) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tick_width", 32'(frame_tick), 32'd0);
          chk("seq_state", 32'(seq_state), 32'(e));
          chk("mode_bit", 32'(mode_bit), 32'(e[1]));
          chk("color_3b", 32'(color_3b), 32'(e[0]));
          last_state = e;
        end
      end else if (seq_state != prev_seq) begin
        chk("change_outside_tick", 32'(seq_state), 32'(prev_seq));
      end
      if (frame_tick && !prev_tick) chk("state_during_tick", 32'(seq_state), 32'(last_state));
      prev_tick = frame_tick;
      prev_seq  = seq_state;
    end
  end

  initial begin
    bit hold_r;
    int kind_r;
    reset     = 1'b1;
    vga_vsync = 1'b1 ^ VS_LOW;
    btn_next  = 1'b0;
    btn_hold  = 1'b0;
    repeat (3) @(negedge clk_dot);
    check_reset_outputs("reset");
    reset = 1'b0;
    #1 chk("lfsr_0", random_num, 32'h1);
    @(negedge clk_dot) chk("lfsr_1", random_num, 32'h3);
    @(negedge clk_dot) chk("lfsr_2", random_num, 32'h6);
    @(negedge clk_dot) chk("lfsr_3", random_num, 32'hD);

    // vsync was already active at release: this frame must not tick.
    run_frame(0, 1'b0, 1'b0, 1'b0);
    repeat (13) run_frame(0, 1'b0, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1, 1'b0);
    run_frame(1, 1'b0, 1'b1, 1'b0);
    run_frame(3, 1'b0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b0);

    repeat (4) run_frame(0, 1'b1, 1'b1, 1'b0);
    run_frame(1, 1'b1, 1'b1, 1'b0);
    repeat (5) run_frame(0, 1'b1, 1'b1, 1'b0);
    repeat (4) run_frame(0, 1'b0, 1'b1, 1'b0);

    hold_r = 1'b0;
    for (int i = 0; i < 40; i++) begin
      kind_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) hold_r = !hold_r;
      run_frame(kind_r, hold_r, 1'b1, i == 20);
    end
    run_frame(0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk_dot);
    chk("all_ticks_seen", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
